// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: FSM state encoding, line levels, counter sizing.
// The matching receiver imports this same package so both ends agree on encodings.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // One spare bit so a counter can hold its terminal value even when n is a power of two.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: bit_done pulses every CLKS_PER_BIT cycles while clear is low.
// Zero-latency pulse off the counter register; no backpressure.
module serial_tx_bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  // Compare against CLKS_PER_BIT-1 as a constant so CLKS_PER_BIT=1 never underflows.
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last   = (r_cnt == LAST);
  assign bit_done = w_last && !clear;

  always_ff @(negedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W bits LSB-first, stop bit; all outputs registered.
// Frame is (DATA_W+2)*CLKS_PER_BIT cycles; tx_ready only in IDLE, so the producer stalls for a whole frame.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              tx_busy
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_cnt_nxt;
  logic              r_line;
  logic              r_ready;
  logic              r_busy;
  logic              w_line_nxt;
  logic              w_ready_nxt;
  logic              w_busy_nxt;
  logic              w_bit_done;
  logic              w_timer_clear;
  logic              w_accept;

  assign w_accept      = tx_valid && r_ready;
  // Timer is held at zero while idle so the start bit gets a full period from the accept edge.
  assign w_timer_clear = (r_state == S_IDLE);

  serial_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_timer_clear),
    .bit_done (w_bit_done)
  );

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_line    <= LINE_IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_line    <= w_line_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = tx_data;
          w_bit_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt   = S_STOP;
            w_bit_cnt_nxt = '0;
          end else begin
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    w_line_nxt  = LINE_IDLE;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b1;
    case (w_state_nxt)
      S_IDLE: begin
        w_line_nxt  = LINE_IDLE;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end
      S_START: w_line_nxt = LINE_START;
      S_DATA:  w_line_nxt = w_shift_nxt[0];
      S_STOP:  w_line_nxt = LINE_IDLE;
      default: w_line_nxt = LINE_IDLE;
    endcase
  end

  assign tx_ready = r_ready;
  assign tx_line  = r_line;
  assign tx_busy  = r_busy;

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: directed frames plus a randomized scoreboard against a mid-bit sampling receiver model.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_line;
  logic       tx_busy;

  logic [3:0] d1_data;
  logic       d1_valid;
  logic       d1_ready;
  logic       d1_line;
  logic       d1_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_line  (tx_line),
    .tx_busy  (tx_busy)
  );

  serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (d1_data),
    .tx_valid (d1_valid),
    .tx_ready (d1_ready),
    .tx_line  (d1_line),
    .tx_busy  (d1_busy)
  );

  // Advance past the next active (falling) edge and let outputs settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the accept edge for an 8-bit word at 4 clocks per bit.
  function automatic logic frame_bit(input logic [7:0] w, input int k);
    int idx;
    idx = k / 4;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    return 1'b1;
  endfunction

  // Called right after the accept edge; returns after the edge that goes back to idle.
  task automatic frame_check(input logic [7:0] w, input string tag);
    for (int k = 0; k < 40; k++) begin
      check($sformatf("%s_line%0d", tag, k), {31'd0, tx_line}, {31'd0, frame_bit(w, k)});
      check($sformatf("%s_busy%0d", tag, k), {31'd0, tx_busy}, 32'd1);
      check($sformatf("%s_rdy%0d", tag, k), {31'd0, tx_ready}, 32'd0);
      step();
    end
    check($sformatf("%s_end_rdy", tag), {31'd0, tx_ready}, 32'd1);
    check($sformatf("%s_end_busy", tag), {31'd0, tx_busy}, 32'd0);
    check($sformatf("%s_end_line", tag), {31'd0, tx_line}, 32'd1);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  rx_word;
    logic [7:0]  exp_word;
    logic        acc;
    bit          rx_active;
    int          rx_cyc;
    int          idx;
    int          sent;
    int          got;
    int          gap;
    int          cyc;
    int          exp5[6];

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    d1_valid = 1'b0;
    d1_data  = 4'h0;

    // Reset and idle line
    step();
    step();
    check("rst_line", {31'd0, tx_line}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_d1_ready", {31'd0, d1_ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle_line%0d", i), {31'd0, tx_line}, 32'd1);
      check($sformatf("idle_busy%0d", i), {31'd0, tx_busy}, 32'd0);
    end

    // Single frame, data changed while in flight
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    frame_check(8'hA5, "a5");

    // Back-to-back with tx_valid held high
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    step();
    tx_data = 8'hFF;
    frame_check(8'h00, "b2b0");
    step();
    tx_valid = 1'b0;
    tx_data  = 8'h12;
    frame_check(8'hFF, "b2b1");

    // Reset mid-frame, then reset together with valid
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    step();
    tx_valid = 1'b0;
    repeat (16) step();
    check("mid_busy", {31'd0, tx_busy}, 32'd1);
    check("mid_line", {31'd0, tx_line}, {31'd0, frame_bit(8'h3C, 16)});
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    step();
    check("abort_line", {31'd0, tx_line}, 32'd1);
    check("abort_ready", {31'd0, tx_ready}, 32'd1);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    step();
    check("rst_vs_valid_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_vs_valid_line", {31'd0, tx_line}, 32'd1);
    reset = 1'b0;
    step();
    tx_valid = 1'b0;
    frame_check(8'h81, "post_rst");

    // One clock per bit, 4-bit word
    exp5 = '{0, 1, 0, 0, 1, 1};
    d1_valid = 1'b1;
    d1_data  = 4'b1001;
    step();
    d1_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("cpb1_line%0d", k), {31'd0, d1_line}, exp5[k]);
      check($sformatf("cpb1_busy%0d", k), {31'd0, d1_busy}, 32'd1);
      step();
    end
    check("cpb1_end_ready", {31'd0, d1_ready}, 32'd1);
    check("cpb1_end_line", {31'd0, d1_line}, 32'd1);

    // Random words, random gaps, reference receiver
    rx_active = 1'b0;
    rx_cyc    = 0;
    rx_word   = 8'h00;
    sent      = 0;
    got       = 0;
    cyc       = 0;
    gap       = $urandom_range(0, 3);
    tx_data   = 8'($urandom);
    while (got < 200 && cyc < 20000) begin
      acc = tx_valid && tx_ready;
      if (acc) q.push_back(tx_data);
      step();
      cyc++;
      if (!rx_active) begin
        if (tx_line == 1'b0) begin
          rx_active = 1'b1;
          rx_cyc    = 0;
        end
      end else begin
        rx_cyc++;
      end
      if (rx_active && (rx_cyc % 4) == 2) begin
        idx = rx_cyc / 4;
        if (idx == 0) begin
          check("sb_start", {31'd0, tx_line}, 32'd0);
        end else if (idx <= 8) begin
          rx_word[idx-1] = tx_line;
        end else begin
          check($sformatf("sb_stop%0d", got), {31'd0, tx_line}, 32'd1);
          check("sb_have_expected", {31'd0, (q.size() > 0)}, 32'd1);
          if (q.size() > 0) begin
            exp_word = q.pop_front();
            check($sformatf("sb_word%0d", got), {24'd0, rx_word}, {24'd0, exp_word});
          end
          got++;
          rx_active = 1'b0;
        end
      end
      if (acc) begin
        sent++;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        gap      = $urandom_range(0, 3);
      end else if (!tx_valid && sent < 200) begin
        if (gap == 0) tx_valid = 1'b1;
        else gap--;
      end
    end
    check("sb_received", got, 32'd200);
    check("sb_sent", sent, 32'd200);
    check("sb_queue_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
